pipe_result_collector: RTL and testbench

Receive-side endpoint for fixed-latency, non-stallable compute pipelines whose output valid is produced by a delay-line valid generator. It grants issue credits so that every result in flight is guaranteed a buffer slot. It captures each result on res_vld into a first-word-fall-through FIFO and presents it downstream on a ready/valid interface. It sits between the PE array output and the writeback/DMA stage.

---
 rtl/pipe_result_collector.sv | 112 +++++++++++
 tb/tb_pipe_result_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_collector.sv
// Credit-gated result collector: grants pipeline issue slots so every in-flight
// result has a buffer entry, then drains results through a FWFT ready/valid FIFO.
module pipe_result_collector #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_req,
  output logic                  issue_grant,
  input  logic                  res_vld,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_rdy,
  output logic [CNT_W-1:0]      inflight,
  output logic [CNT_W-1:0]      fifo_cnt,
  output logic                  err_ovf,
  output logic                  err_unexp
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0]  DEPTH_X = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]  ONE_X   = (CNT_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Up/down counter step; floors at zero and saturates at all-ones so it never wraps.
  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] cur,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W:0] ext;
    ext = {1'b0, cur};
    if (inc && !dec) begin
      ext = ext + ONE_X;
    end else if (dec && !inc && (cur != '0)) begin
      ext = ext - ONE_X;
    end
    if (ext[CNT_W]) begin
      return '1;
    end
    return ext[CNT_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      inflight_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic                  ovf_q;
  logic                  unexp_q;

  logic [CNT_W:0]        credit_sum;
  logic                  grant;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  unexp;

  // Credits come from registered counts only: a pop frees its credit one cycle later.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign grant      = issue_req & (credit_sum < DEPTH_X);
  assign fifo_full  = ({1'b0, fifo_cnt_q} >= DEPTH_X);

  assign out_vld    = (fifo_cnt_q != '0);
  assign out_data   = mem[rd_ptr];
  assign pop        = out_vld & out_rdy;
  assign push       = res_vld & (~fifo_full | pop);
  assign drop       = res_vld & ~push;
  assign unexp      = res_vld & (inflight_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ovf_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      inflight_q <= step_cnt(inflight_q, grant, res_vld);
      fifo_cnt_q <= step_cnt(fifo_cnt_q, push, pop);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (unexp) begin
        unexp_q <= 1'b1;
      end
    end
  end

  // Storage is datapath only; its contents are meaningless until written after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  assign issue_grant = grant;
  assign inflight    = inflight_q;
  assign fifo_cnt    = fifo_cnt_q;
  assign err_ovf     = ovf_q;
  assign err_unexp   = unexp_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Randomized bench for pipe_result_collector against a queue-based model of the
// credit, FIFO and error rules, with a 16-cycle pipeline return model.
module tb_pipe_result_collector;

  localparam int DW    = 256;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int LAT   = 16;

  logic          clk;
  logic          rst_n;
  logic          issue_req;
  logic          issue_grant;
  logic          res_vld;
  logic [DW-1:0] res_data;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          out_rdy;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic          err_ovf;
  logic          err_unexp;

  pipe_result_collector #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_req  (issue_req),
    .issue_grant(issue_grant),
    .res_vld    (res_vld),
    .res_data   (res_data),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_rdy    (out_rdy),
    .inflight   (inflight),
    .fifo_cnt   (fifo_cnt),
    .err_ovf    (err_ovf),
    .err_unexp  (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int            m_inflight;
  logic [DW-1:0] m_q[$];
  bit            m_ovf;
  bit            m_unexp;
  int            cyc;
  int            pend_due[$];
  logic [DW-1:0] pend_dat[$];
  int            pat;
  int            seq;
  int            grants_seen;
  int            pops_seen;

  task automatic model_clear();
    m_inflight = 0;
    m_q.delete();
    m_ovf   = 1'b0;
    m_unexp = 1'b0;
    pend_due.delete();
    pend_dat.delete();
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+2, advance model, wait edge.
  task automatic step(input bit req, input bit rdy, input bit frc, input logic [DW-1:0] fdat);
    bit            rv;
    bit            g;
    bit            p;
    bit            pu;
    logic [DW-1:0] rd;
    logic [DW-1:0] nd;
    rv = frc;
    rd = fdat;
    if (!frc && pend_due.size() > 0 && pend_due[0] == cyc) begin
      rv = 1'b1;
      rd = pend_dat[0];
      void'(pend_due.pop_front());
      void'(pend_dat.pop_front());
    end
    issue_req = req;
    out_rdy   = rdy;
    res_vld   = rv;
    res_data  = rv ? rd : {8{$urandom}};
    #1;
    g  = req && ((m_inflight + m_q.size()) < DEPTH);
    p  = (m_q.size() > 0) && rdy;
    pu = rv && ((m_q.size() < DEPTH) || p);
    chk("issue_grant", 256'(issue_grant), 256'(g));
    chk("out_vld", 256'(out_vld), 256'(m_q.size() > 0));
    if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
    chk("inflight", 256'(inflight), 256'(m_inflight));
    chk("fifo_cnt", 256'(fifo_cnt), 256'(m_q.size()));
    chk("err_ovf", 256'(err_ovf), 256'(m_ovf));
    chk("err_unexp", 256'(err_unexp), 256'(m_unexp));
    if (issue_grant) grants_seen++;
    if (rv && m_inflight == 0) m_unexp = 1'b1;
    if (rv && !pu) m_ovf = 1'b1;
    if (g && !rv) m_inflight++;
    else if (rv && !g && m_inflight > 0) m_inflight--;
    if (p) begin
      void'(m_q.pop_front());
      pops_seen++;
    end
    if (pu) m_q.push_back(rd);
    if (g) begin
      case (pat)
        0:       nd = {32{8'hA5}};
        1:       nd = DW'(seq);
        default: nd = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
      endcase
      pend_due.push_back(cyc + LAT);
      pend_dat.push_back(nd);
      seq++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    issue_req = 1'b0;
    res_vld   = 1'b0;
    out_rdy   = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_vld", 256'(out_vld), 256'(0));
    chk("rst_grant", 256'(issue_grant), 256'(0));
    chk("rst_inflight", 256'(inflight), 256'(0));
    chk("rst_fifo_cnt", 256'(fifo_cnt), 256'(0));
    chk("rst_err_ovf", 256'(err_ovf), 256'(0));
    chk("rst_err_unexp", 256'(err_unexp), 256'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    pat = 0;
    seq = 0;
    grants_seen = 0;
    pops_seen = 0;
    rst_n = 1'b0;
    issue_req = 1'b0;
    res_vld = 1'b0;
    res_data = '0;
    out_rdy = 1'b0;
    model_clear();
    #3;
    do_reset();

    // Idle after reset
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);

    // Single op round trip with A5 pattern
    pat = 0;
    step(1'b1, 1'b1, 1'b0, '0);
    repeat (LAT + 3) step(1'b0, 1'b1, 1'b0, '0);

    // Backpressure fill: exactly DEPTH grants, then drain in order with req held
    pat = 1;
    seq = 0;
    grants_seen = 0;
    repeat (20) step(1'b1, 1'b0, 1'b0, '0);
    repeat (LAT + 1) step(1'b0, 1'b0, 1'b0, '0);
    chk("fill_grants", 256'(grants_seen), 256'(DEPTH));
    chk("fill_cnt", 256'(fifo_cnt), 256'(DEPTH));
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);
    repeat (LAT + 20) step(1'b0, 1'b1, 1'b0, '0);
    chk("drain_empty", 256'(out_vld), 256'(0));

    // Full FIFO: push with pop keeps count, push without pop drops
    seq = 100;
    repeat (20) step(1'b1, 1'b0, 1'b0, '0);
    repeat (LAT + 2) step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, {32{8'h5A}});
    chk("full_pp_cnt", 256'(fifo_cnt), 256'(DEPTH));
    chk("full_pp_ovf", 256'(err_ovf), 256'(0));
    step(1'b0, 1'b0, 1'b1, {32{8'h77}});
    chk("full_drop_ovf", 256'(err_ovf), 256'(1));
    repeat (DEPTH + 2) step(1'b0, 1'b1, 1'b0, '0);

    // Unexpected result with nothing in flight is still buffered
    do_reset();
    step(1'b0, 1'b1, 1'b1, {32{8'h3C}});
    chk("unexp_flag", 256'(err_unexp), 256'(1));
    chk("unexp_data", out_data, {32{8'h3C}});
    step(1'b0, 1'b1, 1'b0, '0);

    // Random stream of 40 words across pointer wrap
    do_reset();
    pat = 2;
    seq = 0;
    pops_seen = 0;
    for (int k = 0; k < 3000 && pops_seen < 40; k++) begin
      step((seq < 40) && ($urandom_range(0, 1) == 1), $urandom_range(0, 2) != 0, 1'b0, '0);
    end
    chk("stream_done", 256'(pops_seen >= 40), 256'(1));

    // Second random stream interrupted by reset mid-flight
    do_reset();
    seq = 0;
    repeat (30) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, '0);
    do_reset();
    repeat (LAT + 8) step($urandom_range(0, 1) == 1, 1'b1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
